// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM-controller signals shared by the arbiter.
// The master side drives requests and controller read data; the slave side is the arbiter.
interface sdram_arbiter_if;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic        vid_ack;
  logic [63:0] vid_data;

  logic        dma_req, blt_req, cpu_req;
  logic        dma_we,  blt_we,  cpu_we;
  logic [23:0] dma_addr, blt_addr, cpu_addr;
  logic [15:0] dma_din,  blt_din,  cpu_din;
  logic [1:0]  dma_ds,   blt_ds,   cpu_ds;
  logic        dma_ack,  blt_ack,  cpu_ack;
  logic [15:0] dma_dout, blt_dout, cpu_dout;

  logic        sd_req;
  logic        sd_we;
  logic [23:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_ds;
  logic [15:0] sd_dout;
  logic [63:0] sd_dout64;
  logic [1:0]  grant;

  modport master (
    output vid_req, vid_addr,
    output dma_req, blt_req, cpu_req, dma_we, blt_we, cpu_we,
    output dma_addr, blt_addr, cpu_addr, dma_din, blt_din, cpu_din,
    output dma_ds, blt_ds, cpu_ds,
    output sd_dout, sd_dout64,
    input  vid_ack, vid_data, dma_ack, blt_ack, cpu_ack,
    input  dma_dout, blt_dout, cpu_dout,
    input  sd_req, sd_we, sd_addr, sd_din, sd_ds, grant
  );

  modport slave (
    input  vid_req, vid_addr,
    input  dma_req, blt_req, cpu_req, dma_we, blt_we, cpu_we,
    input  dma_addr, blt_addr, cpu_addr, dma_din, blt_din, cpu_din,
    input  dma_ds, blt_ds, cpu_ds,
    input  sd_dout, sd_dout64,
    output vid_ack, vid_data, dma_ack, blt_ack, cpu_ack,
    output dma_dout, blt_dout, cpu_dout,
    output sd_req, sd_we, sd_addr, sd_din, sd_ds, grant
  );
endinterface

// File: rtl/sdram_arbiter.sv
// One SDRAM slot per 8 MHz cycle shared by video, DMA, blitter and CPU.
// Slot phase is locked to clk_8_en; winner is registered entering ARB_PHASE, completion entering DONE_PHASE.
module sdram_arbiter #(
  parameter int ARB_PHASE  = 11,
  parameter int DONE_PHASE = 9,
  parameter int SLOT_LEN   = 12
) (
  input  logic           clk_96,
  input  logic           init,
  input  logic           clk_8_en,
  sdram_arbiter_if.slave bus
);
  localparam int            PW      = $clog2(SLOT_LEN);
  localparam logic [PW-1:0] ARB_PH  = PW'(ARB_PHASE);
  localparam logic [PW-1:0] DONE_PH = PW'(DONE_PHASE);
  localparam logic [PW-1:0] LAST_PH = PW'(SLOT_LEN - 1);

  typedef enum logic [1:0] {ID_VID = 2'd0, ID_DMA = 2'd1, ID_BLT = 2'd2, ID_CPU = 2'd3} id_e;

  // Requesters viewed by id; video is read-only with both strobes set.
  logic [3:0]       req, we;
  logic [3:0][23:0] addr;
  logic [3:0][15:0] din;
  logic [3:0][1:0]  ds;

  assign req  = {bus.cpu_req,  bus.blt_req,  bus.dma_req,  bus.vid_req};
  assign we   = {bus.cpu_we,   bus.blt_we,   bus.dma_we,   1'b0};
  assign addr = {bus.cpu_addr, bus.blt_addr, bus.dma_addr, bus.vid_addr};
  assign din  = {bus.cpu_din,  bus.blt_din,  bus.dma_din,  16'h0000};
  assign ds   = {bus.cpu_ds,   bus.blt_ds,   bus.dma_ds,   2'b11};

  logic          en_prev_q;
  logic [PW-1:0] ph_q, ph_d;
  logic          locked_q, locked_d;
  logic          cpu_first_q, cpu_first_d;
  logic          pend_q, pend_d;
  logic          sd_req_q, sd_req_d, sd_we_q, sd_we_d;
  logic [23:0]   sd_addr_q, sd_addr_d;
  logic [15:0]   sd_din_q, sd_din_d;
  logic [1:0]    sd_ds_q, sd_ds_d;
  id_e           grant_q, grant_d;
  logic [3:0]    ack_q, ack_d;
  logic [15:0]   dma_dout_q, dma_dout_d, blt_dout_q, blt_dout_d, cpu_dout_q, cpu_dout_d;
  logic [63:0]   vid_data_q, vid_data_d;

  logic en_edge, arb_now, done_now, win_vld;
  id_e  win_id;

  always_comb begin
    win_vld = 1'b1;
    win_id  = ID_VID;
    if (req[ID_VID])                     win_id = ID_VID;
    else if (req[ID_DMA])                win_id = ID_DMA;
    else if (req[ID_BLT] && req[ID_CPU]) win_id = cpu_first_q ? ID_CPU : ID_BLT;
    else if (req[ID_BLT])                win_id = ID_BLT;
    else if (req[ID_CPU])                win_id = ID_CPU;
    else                                 win_vld = 1'b0;
  end

  always_comb begin
    en_edge     = clk_8_en & ~en_prev_q;
    ph_d        = (en_edge || ph_q == LAST_PH) ? '0 : ph_q + PW'(1);
    locked_d    = locked_q | en_edge;
    arb_now     = locked_q && (ph_d == ARB_PH);
    done_now    = pend_q && (ph_d == DONE_PH);

    cpu_first_d = cpu_first_q;
    pend_d      = pend_q;
    sd_req_d    = sd_req_q;
    sd_we_d     = sd_we_q;
    sd_addr_d   = sd_addr_q;
    sd_din_d    = sd_din_q;
    sd_ds_d     = sd_ds_q;
    grant_d     = grant_q;
    ack_d       = '0;
    dma_dout_d  = dma_dout_q;
    blt_dout_d  = blt_dout_q;
    cpu_dout_d  = cpu_dout_q;
    vid_data_d  = vid_data_q;

    if (arb_now) begin
      sd_req_d = win_vld;
      pend_d   = win_vld;
      if (win_vld) begin
        grant_d   = win_id;
        sd_we_d   = we[win_id];
        sd_addr_d = addr[win_id];
        sd_din_d  = din[win_id];
        sd_ds_d   = ds[win_id];
        if (win_id == ID_BLT)      cpu_first_d = 1'b1;
        else if (win_id == ID_CPU) cpu_first_d = 1'b0;
      end
    end

    if (done_now) begin
      pend_d         = 1'b0;
      ack_d[grant_q] = 1'b1;
      if (!sd_we_q) begin
        case (grant_q)
          ID_VID:  vid_data_d = bus.sd_dout64;
          ID_DMA:  dma_dout_d = bus.sd_dout;
          ID_BLT:  blt_dout_d = bus.sd_dout;
          default: cpu_dout_d = bus.sd_dout;
        endcase
      end
    end
  end

  always_ff @(posedge clk_96 or posedge init) begin
    if (init) begin
      // Treat enable as already high so a real low->high transition is needed to lock.
      en_prev_q   <= 1'b1;
      ph_q        <= '0;
      locked_q    <= 1'b0;
      cpu_first_q <= 1'b1;
      pend_q      <= 1'b0;
      sd_req_q    <= 1'b0;
      sd_we_q     <= 1'b0;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
      sd_ds_q     <= '0;
      grant_q     <= ID_VID;
      ack_q       <= '0;
      dma_dout_q  <= '0;
      blt_dout_q  <= '0;
      cpu_dout_q  <= '0;
      vid_data_q  <= '0;
    end else begin
      en_prev_q   <= clk_8_en;
      ph_q        <= ph_d;
      locked_q    <= locked_d;
      cpu_first_q <= cpu_first_d;
      pend_q      <= pend_d;
      sd_req_q    <= sd_req_d;
      sd_we_q     <= sd_we_d;
      sd_addr_q   <= sd_addr_d;
      sd_din_q    <= sd_din_d;
      sd_ds_q     <= sd_ds_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      dma_dout_q  <= dma_dout_d;
      blt_dout_q  <= blt_dout_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_data_q  <= vid_data_d;
    end
  end

  assign bus.sd_req   = sd_req_q;
  assign bus.sd_we    = sd_we_q;
  assign bus.sd_addr  = sd_addr_q;
  assign bus.sd_din   = sd_din_q;
  assign bus.sd_ds    = sd_ds_q;
  assign bus.grant    = grant_q;
  assign bus.vid_ack  = ack_q[ID_VID];
  assign bus.dma_ack  = ack_q[ID_DMA];
  assign bus.blt_ack  = ack_q[ID_BLT];
  assign bus.cpu_ack  = ack_q[ID_CPU];
  assign bus.vid_data = vid_data_q;
  assign bus.dma_dout = dma_dout_q;
  assign bus.blt_dout = blt_dout_q;
  assign bus.cpu_dout = cpu_dout_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: slot table plus init-abort and resync sequences.
module tb_sdram_arbiter;
  logic clk_96 = 1'b0;
  logic init;
  logic clk_8_en;

  sdram_arbiter_if bus ();

  sdram_arbiter dut (
    .clk_96   (clk_96),
    .init     (init),
    .clk_8_en (clk_8_en),
    .bus      (bus)
  );

  always #5 clk_96 = ~clk_96;

  localparam logic [23:0] VA  = 24'h100040;
  localparam logic [23:0] DA  = 24'h200080;
  localparam logic [23:0] BA  = 24'h3000C0;
  localparam logic [23:0] CA  = 24'h001234;
  localparam logic [63:0] D64 = 64'h0123456789ABCDEF;

  typedef struct {
    logic [3:0]  req;
    logic        we;
    logic [1:0]  ds;
    logic [15:0] din;
    logic [15:0] sdout;
    logic [1:0]  e_grant;
    logic        e_req;
    logic        e_we;
    logic [23:0] e_addr;
    logic        e_din_chk;
    logic [15:0] e_din;
    logic [1:0]  e_ds;
    logic [3:0]  e_ack;
    logic [15:0] e_dma, e_blt, e_cpu;
    logic [63:0] e_vid;
  } vec_t;

  int n_chk = 0, n_bad = 0;
  int mph = 0, gen_cnt = 0;
  bit m_prev = 1'b1, m_locked = 1'b0, gen_on = 1'b0;
  int cpu_ack_cnt = 0;

  always @(negedge clk_96) if (bus.cpu_ack) cpu_ack_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clk_96 cycle; tracks slot phase from the enable the bench drove, then drives the next enable.
  task automatic tick();
    @(posedge clk_96);
    #1;
    if (init) begin
      m_prev = 1'b1; m_locked = 1'b0; mph = 0;
    end else begin
      if (clk_8_en && !m_prev) begin mph = 0; m_locked = 1'b1; end
      else mph = (mph + 1) % 12;
      m_prev = clk_8_en;
    end
    if (gen_on) begin
      clk_8_en = (gen_cnt < 6);
      gen_cnt  = (gen_cnt + 1) % 12;
    end else clk_8_en = 1'b0;
  endtask

  task automatic wait_ph(input int p, input string nm);
    int n = 0;
    while (!(m_locked && mph == p) && n < 40) begin tick(); n++; end
    if (!(m_locked && mph == p)) begin
      n_chk++; n_bad++;
      $display("FAIL timeout_%s: got phase %0d, expected phase %0d", nm, mph, p);
    end
  endtask

  function automatic vec_t mk(logic [3:0] req, logic we, logic [1:0] ds, logic [15:0] din, logic [15:0] sdout,
                              logic [1:0] g, logic r, logic ewe, logic [23:0] a, logic dchk, logic [15:0] edin,
                              logic [1:0] eds, logic [3:0] ack, logic [15:0] dd, logic [15:0] bd, logic [15:0] cd,
                              logic [63:0] vd);
    vec_t v;
    v.req = req; v.we = we; v.ds = ds; v.din = din; v.sdout = sdout;
    v.e_grant = g; v.e_req = r; v.e_we = ewe; v.e_addr = a; v.e_din_chk = dchk; v.e_din = edin;
    v.e_ds = eds; v.e_ack = ack; v.e_dma = dd; v.e_blt = bd; v.e_cpu = cd; v.e_vid = vd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.vid_req = v.req[0]; bus.dma_req = v.req[1]; bus.blt_req = v.req[2]; bus.cpu_req = v.req[3];
    bus.dma_we = v.we;  bus.blt_we = v.we;  bus.cpu_we = v.we;
    bus.dma_ds = v.ds;  bus.blt_ds = v.ds;  bus.cpu_ds = v.ds;
    bus.dma_din = v.din; bus.blt_din = v.din; bus.cpu_din = v.din;
    bus.sd_dout = v.sdout;
  endtask

  function automatic logic [3:0] acks();
    return {bus.cpu_ack, bus.blt_ack, bus.dma_ack, bus.vid_ack};
  endfunction

  vec_t vt[12];

  initial begin
    int ack0, bad;
    // req mask is {cpu,blt,dma,vid}
    vt[0]  = mk(4'b1000, 1'b0, 2'b11, 16'h1111, 16'hBEEF, 2'd3, 1'b1, 1'b0, CA, 1'b1, 16'h1111, 2'b11, 4'b1000, 16'h0000, 16'h0000, 16'hBEEF, 64'h0);
    vt[1]  = mk(4'b1011, 1'b1, 2'b10, 16'h2222, 16'hCAFE, 2'd0, 1'b1, 1'b0, VA, 1'b0, 16'h0000, 2'b11, 4'b0001, 16'h0000, 16'h0000, 16'hBEEF, D64);
    vt[2]  = mk(4'b1010, 1'b0, 2'b10, 16'h2222, 16'h5A5A, 2'd1, 1'b1, 1'b0, DA, 1'b1, 16'h2222, 2'b10, 4'b0010, 16'h5A5A, 16'h0000, 16'hBEEF, D64);
    vt[3]  = mk(4'b1000, 1'b0, 2'b11, 16'h3333, 16'h7777, 2'd3, 1'b1, 1'b0, CA, 1'b1, 16'h3333, 2'b11, 4'b1000, 16'h5A5A, 16'h0000, 16'h7777, D64);
    vt[4]  = mk(4'b1100, 1'b0, 2'b11, 16'h4444, 16'h1357, 2'd2, 1'b1, 1'b0, BA, 1'b1, 16'h4444, 2'b11, 4'b0100, 16'h5A5A, 16'h1357, 16'h7777, D64);
    vt[5]  = mk(4'b1100, 1'b0, 2'b11, 16'h5555, 16'h2468, 2'd3, 1'b1, 1'b0, CA, 1'b1, 16'h5555, 2'b11, 4'b1000, 16'h5A5A, 16'h1357, 16'h2468, D64);
    vt[6]  = mk(4'b1100, 1'b0, 2'b11, 16'h6666, 16'h1122, 2'd2, 1'b1, 1'b0, BA, 1'b1, 16'h6666, 2'b11, 4'b0100, 16'h5A5A, 16'h1122, 16'h2468, D64);
    vt[7]  = mk(4'b1100, 1'b0, 2'b11, 16'h7777, 16'h3344, 2'd3, 1'b1, 1'b0, CA, 1'b1, 16'h7777, 2'b11, 4'b1000, 16'h5A5A, 16'h1122, 16'h3344, D64);
    vt[8]  = mk(4'b0010, 1'b1, 2'b01, 16'h00A5, 16'hFFFF, 2'd1, 1'b1, 1'b1, DA, 1'b1, 16'h00A5, 2'b01, 4'b0010, 16'h5A5A, 16'h1122, 16'h3344, D64);
    for (int i = 9; i < 12; i++)
      vt[i] = mk(4'b0000, 1'b0, 2'b11, 16'h0000, 16'hDEAD, 2'd1, 1'b0, 1'b1, DA, 1'b1, 16'h00A5, 2'b01, 4'b0000, 16'h5A5A, 16'h1122, 16'h3344, D64);

    init = 1'b1; clk_8_en = 1'b0;
    bus.vid_addr = VA; bus.dma_addr = DA; bus.blt_addr = BA; bus.cpu_addr = CA;
    bus.sd_dout64 = D64;
    drive(mk(4'b0000, 1'b0, 2'b00, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 24'h0, 1'b0, 16'h0, 2'b00, 4'h0, 16'h0, 16'h0, 16'h0, 64'h0));
    repeat (3) tick();
    chk("rst_sd", {bus.sd_req, bus.sd_we, bus.sd_addr, bus.sd_din, bus.sd_ds, bus.grant}, 64'h0);
    chk("rst_ack", acks(), 64'h0);
    chk("rst_dout", {bus.dma_dout, bus.blt_dout, bus.cpu_dout}, 64'h0);
    chk("rst_vid", bus.vid_data, 64'h0);

    init = 1'b0; gen_on = 1'b1; gen_cnt = 0;
    wait_ph(0, "lock");

    foreach (vt[i]) begin
      drive(vt[i]);
      wait_ph(11, $sformatf("v%0d_arb", i));
      chk($sformatf("v%0d_grant", i), bus.grant, vt[i].e_grant);
      chk($sformatf("v%0d_sd_req", i), bus.sd_req, vt[i].e_req);
      chk($sformatf("v%0d_sd_we", i), bus.sd_we, vt[i].e_we);
      chk($sformatf("v%0d_sd_addr", i), bus.sd_addr, vt[i].e_addr);
      if (vt[i].e_din_chk) chk($sformatf("v%0d_sd_din", i), bus.sd_din, vt[i].e_din);
      chk($sformatf("v%0d_sd_ds", i), bus.sd_ds, vt[i].e_ds);
      wait_ph(9, $sformatf("v%0d_done", i));
      chk($sformatf("v%0d_ack", i), acks(), vt[i].e_ack);
      tick();
      chk($sformatf("v%0d_ack_width", i), acks(), 64'h0);
      chk($sformatf("v%0d_dma_dout", i), bus.dma_dout, vt[i].e_dma);
      chk($sformatf("v%0d_blt_dout", i), bus.blt_dout, vt[i].e_blt);
      chk($sformatf("v%0d_cpu_dout", i), bus.cpu_dout, vt[i].e_cpu);
      chk($sformatf("v%0d_vid_data", i), bus.vid_data, vt[i].e_vid);
    end

    // init pulsed in the middle of a granted CPU slot
    drive(mk(4'b1000, 1'b0, 2'b11, 16'h0, 16'h9999, 2'd0, 1'b0, 1'b0, 24'h0, 1'b0, 16'h0, 2'b00, 4'h0, 16'h0, 16'h0, 16'h0, 64'h0));
    wait_ph(11, "abort_arb");
    chk("abort_grant", {bus.sd_req, bus.grant}, {1'b1, 2'd3});
    wait_ph(5, "abort_ph5");
    ack0 = cpu_ack_cnt;
    init = 1'b1;
    #1;
    chk("abort_sd", {bus.sd_req, bus.sd_we, bus.sd_addr, bus.sd_din, bus.sd_ds, bus.grant}, 64'h0);
    chk("abort_ack", acks(), 64'h0);
    chk("abort_dout", {bus.dma_dout, bus.blt_dout, bus.cpu_dout}, 64'h0);
    chk("abort_vid", bus.vid_data, 64'h0);
    repeat (2) tick();
    init = 1'b0;
    bad = 0;
    for (int n = 0; n < 30 && !m_locked; n++) begin
      tick();
      if (bus.sd_req || bus.cpu_ack) bad++;
    end
    chk("abort_no_grant_unlocked", bad, 64'h0);
    chk("abort_no_ack", cpu_ack_cnt - ack0, 64'h0);
    wait_ph(11, "relock_arb");
    chk("relock_grant", {bus.sd_req, bus.grant, bus.sd_addr}, {1'b1, 2'd3, CA});
    wait_ph(9, "relock_done");
    chk("relock_ack", acks(), 64'h8);
    chk("relock_cpu_dout", bus.cpu_dout, 16'h9999);
    bus.cpu_req = 1'b0;

    // clk_8_en resync at phase 6 while a CPU slot is pending
    tick();
    bus.cpu_req = 1'b1; bus.cpu_addr = 24'h00ABCD; bus.sd_dout = 16'h4242;
    wait_ph(11, "resync_arb");
    chk("resync_grant", {bus.sd_req, bus.grant, bus.sd_addr}, {1'b1, 2'd3, 24'h00ABCD});
    ack0 = cpu_ack_cnt;
    wait_ph(2, "resync_ph2");
    bus.cpu_addr = 24'hFFFFFF;
    wait_ph(6, "resync_ph6");
    clk_8_en = 1'b1; gen_cnt = 1;
    tick();
    chk("resync_phase", mph, 64'h0);
    chk("resync_no_early_ack", cpu_ack_cnt - ack0, 64'h0);
    wait_ph(9, "resync_done");
    chk("resync_ack", acks(), 64'h8);
    chk("resync_cpu_dout", bus.cpu_dout, 16'h4242);
    chk("resync_addr_held", bus.sd_addr, 24'h00ABCD);
    bus.cpu_req = 1'b0;
    repeat (14) tick();
    chk("resync_single_ack", cpu_ack_cnt - ack0, 64'h1);
    chk("resync_idle_req", bus.sd_req, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
